// File: rtl/bios_boot_loader_pkg.sv
// Shared definitions for the BIOS boot loader: FSM state encoding and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bios_boot_loader_pkg;

    // Copy FSM: ADDR presents the ROM address, WRITE pushes the word to RAM,
    // DONE releases the CPU and waits for a re-boot request.
    typedef enum logic [1:0] {
        ADDR  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } boot_state_t;

    localparam int          DATA_WIDTH_DEF     = 16;
    localparam int          ROM_ADDR_WIDTH_DEF = 9;
    localparam int          RAM_ADDR_WIDTH_DEF = 16;
    localparam int unsigned LOAD_BASE_DEF      = 0;
    localparam int          LOAD_WORDS_DEF     = 512;

endpackage

// File: rtl/bios_boot_loader_if.sv
// Memory-side bus of the boot loader: BIOS ROM read port plus RAM write port.
// Latency: ROM data returns one clk after rom_addr; RAM write completes on an edge with ram_ready=1.
// Backpressure: ram_ready low stalls the write; the master holds ram_we/ram_addr/ram_data stable.
interface bios_boot_loader_if
    import bios_boot_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ROM_ADDR_WIDTH = ROM_ADDR_WIDTH_DEF,
    parameter int RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF
) ();

    logic [ROM_ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0]     rom_q;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]     ram_data;
    logic                      ram_we;
    logic                      ram_ready;

    // Loader side
    modport master (
        output rom_addr,
        input  rom_q,
        output ram_addr,
        output ram_data,
        output ram_we,
        input  ram_ready
    );

    // ROM / RAM side
    modport slave (
        input  rom_addr,
        output rom_q,
        input  ram_addr,
        input  ram_data,
        input  ram_we,
        output ram_ready
    );

endinterface

// File: rtl/bios_boot_loader.sv
// Copies LOAD_WORDS words from the BIOS ROM into RAM at LOAD_BASE while holding the CPU in reset.
// Latency: two cycles per word with ram_ready high (ADDR + WRITE), so 2*LOAD_WORDS to done.
// Backpressure: ram_ready low holds WRITE with all outputs stable, indefinitely.
// Ports: clk, reset (async active-high), start (re-boot, DONE only), mem (ROM/RAM bus,
//        master modport), cpu_hold, done, checksum (running sum of words written).
module bios_boot_loader
    import bios_boot_loader_pkg::*;
#(
    parameter int          DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int          ROM_ADDR_WIDTH = ROM_ADDR_WIDTH_DEF,
    parameter int          RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
    parameter int unsigned LOAD_BASE      = LOAD_BASE_DEF,
    parameter int          LOAD_WORDS     = LOAD_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    bios_boot_loader_if.master    mem,
    output logic                  cpu_hold,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    // Refuse to elaborate with a word count the index register cannot cover.
    if (LOAD_WORDS < 1 || LOAD_WORDS > (1 << ROM_ADDR_WIDTH)) begin : g_bad_load_words
        $error("bios_boot_loader: LOAD_WORDS out of range 1..2**ROM_ADDR_WIDTH");
    end

    // The DONE decision compares against the last index rather than a count,
    // so a full-ROM copy never needs an index one bit wider than the ROM address.
    localparam logic [ROM_ADDR_WIDTH-1:0] LAST_IDX  = ROM_ADDR_WIDTH'(LOAD_WORDS - 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] BASE_ADDR = RAM_ADDR_WIDTH'(LOAD_BASE);

    boot_state_t               state;
    logic [ROM_ADDR_WIDTH-1:0] idx;
    logic                      ram_we_q;

    // ROM address comes straight from idx; the ROM registers it, so rom_q is
    // valid throughout WRITE and stays valid during a stall because idx is frozen.
    assign mem.rom_addr = idx;
    assign mem.ram_addr = BASE_ADDR + RAM_ADDR_WIDTH'(idx);   // wraps modulo 2**RAM_ADDR_WIDTH
    assign mem.ram_data = mem.rom_q;
    assign mem.ram_we   = ram_we_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ADDR;
            idx      <= '0;
            checksum <= '0;
            ram_we_q <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    state    <= WRITE;
                    ram_we_q <= 1'b1;
                end

                WRITE: begin
                    if (mem.ram_ready) begin
                        checksum <= checksum + mem.ram_data;
                        ram_we_q <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state    <= DONE;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ADDR;
                        end
                    end
                end

                DONE: begin
                    if (start) begin
                        state    <= ADDR;
                        idx      <= '0;
                        checksum <= '0;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                    end
                end

                default: begin
                    state    <= ADDR;
                    ram_we_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bios_boot_loader.sv
// Bench for bios_boot_loader: two instances (4 words at base 0, 512 words at base 0xFFFE),
// each with a registered ROM model beside it. Stimulus queues expected RAM writes;
// negedge monitors pop and compare every accepted write and check stall stability.
module tb_bios_boot_loader;
    import bios_boot_loader_pkg::*;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, start_a, start_b;
    logic        cpu_hold_a, done_a, cpu_hold_b, done_b;
    logic [15:0] checksum_a, checksum_b;

    int errors = 0;
    int checks = 0;

    wr_t q_a[$];
    wr_t q_b[$];

    int stall_addr = -1;
    int stall_left = 0;
    bit b_fin = 1'b0;

    bios_boot_loader_if #(.DATA_WIDTH(16), .ROM_ADDR_WIDTH(9), .RAM_ADDR_WIDTH(16)) if_a ();
    bios_boot_loader_if #(.DATA_WIDTH(16), .ROM_ADDR_WIDTH(9), .RAM_ADDR_WIDTH(16)) if_b ();

    bios_boot_loader #(
        .DATA_WIDTH(16), .ROM_ADDR_WIDTH(9), .RAM_ADDR_WIDTH(16),
        .LOAD_BASE(0), .LOAD_WORDS(4)
    ) u_a (
        .clk(clk), .reset(rst_a), .start(start_a), .mem(if_a.master),
        .cpu_hold(cpu_hold_a), .done(done_a), .checksum(checksum_a)
    );

    bios_boot_loader #(
        .DATA_WIDTH(16), .ROM_ADDR_WIDTH(9), .RAM_ADDR_WIDTH(16),
        .LOAD_BASE(32'hFFFE), .LOAD_WORDS(512)
    ) u_b (
        .clk(clk), .reset(rst_b), .start(start_b), .mem(if_b.master),
        .cpu_hold(cpu_hold_b), .done(done_b), .checksum(checksum_b)
    );

    // ROM models: word i = i+1 for instance a, all 0xFFFF for instance b.
    always @(posedge clk) if_a.rom_q <= 16'(if_a.rom_addr) + 16'd1;
    always @(posedge clk) if_b.rom_q <= 16'hFFFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM ready for instance a: high except for a programmed stall on one address.
    initial begin
        if_a.ram_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (if_a.ram_we && int'(if_a.ram_addr) == stall_addr && stall_left > 0) begin
                if_a.ram_ready = 1'b0;
                stall_left--;
            end else begin
                if_a.ram_ready = 1'b1;
            end
        end
    end

    initial if_b.ram_ready = 1'b1;

    // Monitor a: accepted writes against the scoreboard, stalled writes held stable.
    logic        prev_stall_a = 1'b0;
    logic [15:0] held_addr_a, held_data_a;
    always @(negedge clk) begin
        wr_t e;
        if (rst_a) begin
            prev_stall_a = 1'b0;
        end else begin
            if (prev_stall_a) begin
                check("a_stall_we",   32'(if_a.ram_we),   32'd1);
                check("a_stall_addr", 32'(if_a.ram_addr), 32'(held_addr_a));
                check("a_stall_data", 32'(if_a.ram_data), 32'(held_data_a));
            end
            if (if_a.ram_we && if_a.ram_ready) begin
                check("a_write_expected", 32'(q_a.size() > 0), 32'd1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    check("a_write", {if_a.ram_addr, if_a.ram_data}, e);
                end
            end
            prev_stall_a = if_a.ram_we && !if_a.ram_ready;
            held_addr_a  = if_a.ram_addr;
            held_data_a  = if_a.ram_data;
        end
    end

    // Monitor b: accepted writes against the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (!rst_b && if_b.ram_we && if_b.ram_ready) begin
            check("b_write_expected", 32'(q_b.size() > 0), 32'd1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_write", {if_b.ram_addr, if_b.ram_data}, e);
            end
        end
    end

    task automatic push_a();
        for (int i = 0; i < 4; i++) q_a.push_back({16'(i), 16'(i + 1)});
    endtask

    // Counts rising edges until done_a, sampling #1 after each edge. Optionally
    // raises start for one edge after edge number start_at (must be ignored mid-copy).
    task automatic wait_done_a(input int budget, input int start_at, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            start_a = (cyc == start_at);
        end while (!done_a && cyc < budget);
        start_a = 1'b0;
    endtask

    task automatic check_done_a(input string tag, input int cyc, input int exp_cyc);
        check({tag, "_cycles"},   32'(cyc),         32'(exp_cyc));
        check({tag, "_done"},     32'(done_a),      32'd1);
        check({tag, "_cpu_hold"}, 32'(cpu_hold_a),  32'd0);
        check({tag, "_checksum"}, 32'(checksum_a),  32'd10);
        check({tag, "_all_written"}, 32'(q_a.size()), 32'd0);
    endtask

    // Pulse start in DONE and verify the registered re-entry into the copy.
    task automatic restart_a(input string tag);
        #1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check({tag, "_restart_done"},     32'(done_a),     32'd0);
        check({tag, "_restart_cpu_hold"}, 32'(cpu_hold_a), 32'd1);
        check({tag, "_restart_checksum"}, 32'(checksum_a), 32'd0);
    endtask

    // Instance b: 512 words of 0xFFFF at base 0xFFFE, addresses wrap through zero.
    initial begin
        int          cyc;
        logic [15:0] ad;
        rst_b   = 1'b0;
        start_b = 1'b0;
        #1 rst_b = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            ad = 16'hFFFE + 16'(i);
            q_b.push_back({ad, 16'hFFFF});
        end
        rst_b = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done_b && cyc < 1100);
        check("b_cycles",      32'(cyc),         32'd1024);
        check("b_checksum",    32'(checksum_b),  32'h0000FE00);
        check("b_cpu_hold",    32'(cpu_hold_b),  32'd0);
        check("b_all_written", 32'(q_b.size()),  32'd0);
        b_fin = 1'b1;
    end

    // Instance a: main directed sequence, then summary.
    initial begin
        int          cyc;
        logic [15:0] cs1;
        rst_a   = 1'b0;
        start_a = 1'b0;
        #1 rst_a = 1'b1;
        repeat (2) @(negedge clk);

        check("a_reset_ram_we",   32'(if_a.ram_we),   32'd0);
        check("a_reset_cpu_hold", 32'(cpu_hold_a),    32'd1);
        check("a_reset_done",     32'(done_a),        32'd0);
        check("a_reset_checksum", 32'(checksum_a),    32'd0);
        check("a_reset_rom_addr", 32'(if_a.rom_addr), 32'd0);

        // First copy: automatic after reset release.
        push_a();
        rst_a = 1'b0;
        wait_done_a(40, -1, cyc);
        check_done_a("a_copy1", cyc, 8);
        cs1 = checksum_a;

        // Second copy via start; a start pulse mid-copy must be ignored.
        push_a();
        restart_a("a_copy2");
        wait_done_a(40, 3, cyc);
        check_done_a("a_copy2", cyc, 8);
        check("a_copy2_checksum_same", 32'(checksum_a), 32'(cs1));

        // Third copy with RAM stalling word 2 for three cycles.
        push_a();
        stall_addr = 2;
        stall_left = 3;
        restart_a("a_stall");
        wait_done_a(40, -1, cyc);
        check_done_a("a_stall", cyc, 11);
        check("a_stall_consumed", 32'(stall_left), 32'd0);
        stall_addr = -1;

        // Fourth copy: async reset while word 2 is being written.
        push_a();
        restart_a("a_rst");
        cyc = 0;
        while (!(if_a.ram_we && if_a.ram_addr == 16'd2) && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("a_rst_reached_word2", 32'(if_a.ram_we && if_a.ram_addr == 16'd2), 32'd1);
        #1;
        rst_a = 1'b1;
        #1;
        check("a_rst_async_ram_we",   32'(if_a.ram_we),   32'd0);
        check("a_rst_async_cpu_hold", 32'(cpu_hold_a),    32'd1);
        check("a_rst_async_done",     32'(done_a),        32'd0);
        check("a_rst_async_checksum", 32'(checksum_a),    32'd0);
        check("a_rst_async_rom_addr", 32'(if_a.rom_addr), 32'd0);
        q_a.delete();
        push_a();
        @(negedge clk);
        rst_a = 1'b0;
        wait_done_a(40, -1, cyc);
        check_done_a("a_rst_recopy", cyc, 8);

        cyc = 0;
        while (!b_fin && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        check("b_finished", 32'(b_fin), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
